// File: rtl/npc_seq_ctrl.sv
// Fetch/execute sequencer for the NPC core: issues instruction fetches, holds the
// fetched word for decode, gates the regfile write to EXEC, and tracks halt/fault/counters.
module npc_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h80000000,
    parameter int unsigned TIMEOUT  = 255,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    output logic             imem_req_valid,
    input  logic             imem_req_ready,
    output logic [31:0]      imem_addr,
    input  logic             imem_rsp_valid,
    input  logic [31:0]      imem_rsp_data,
    output logic [31:0]      inst,
    output logic [31:0]      pc,
    input  logic             dec_reg_wen,
    output logic             reg_wen,
    output logic             halt,
    output logic             fault,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_FAULT
    } state_t;

    localparam logic [31:0]      INST_NOP    = 32'h00000013;
    localparam logic [31:0]      INST_EBREAK = 32'h00100073;
    localparam logic [16:0]      TO_LIMIT    = 17'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t            r_state;
    state_t            w_next;
    logic [31:0]       r_pc;
    logic [31:0]       r_inst;
    logic              r_halt;
    logic              r_fault;
    logic [CNT_W-1:0]  r_cycle;
    logic [CNT_W-1:0]  r_instret;
    logic [15:0]       r_to;
    logic [16:0]       w_to_inc;
    logic              w_to_hit;
    logic              w_is_ebreak;
    logic              w_active;

    assign w_is_ebreak = (r_inst == INST_EBREAK);
    // One extra bit so TIMEOUT = 65535 is reachable without the counter wrapping.
    assign w_to_inc    = {1'b0, r_to} + 17'd1;
    assign w_to_hit    = (w_to_inc == TO_LIMIT);
    assign w_active    = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_EXEC);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        imem_req_valid = 1'b0;
        reg_wen        = 1'b0;
        case (r_state)
            S_IDLE:  w_next = S_FETCH;
            S_FETCH: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                // A response on the limit edge still wins over the timeout.
                if (imem_rsp_valid)  w_next = S_EXEC;
                else if (w_to_hit)   w_next = S_FAULT;
            end
            S_EXEC: begin
                reg_wen = dec_reg_wen & ~w_is_ebreak;
                w_next  = w_is_ebreak ? S_HALT : S_FETCH;
            end
            default: w_next = r_state;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_inst    <= INST_NOP;
            r_halt    <= 1'b0;
            r_fault   <= 1'b0;
            r_cycle   <= '0;
            r_instret <= '0;
            r_to      <= '0;
        end else begin
            if (w_active) r_cycle <= r_cycle + CNT_ONE;
            case (r_state)
                S_FETCH: begin
                    if (imem_req_ready) r_to <= '0;
                end
                S_WAIT: begin
                    if (imem_rsp_valid) begin
                        r_inst <= imem_rsp_data;
                    end else begin
                        r_to <= w_to_inc[15:0];
                        if (w_to_hit) r_fault <= 1'b1;
                    end
                end
                S_EXEC: begin
                    r_instret <= r_instret + CNT_ONE;
                    if (w_is_ebreak) r_halt <= 1'b1;
                    else             r_pc   <= r_pc + 32'd4;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign inst      = r_inst;
    assign halt      = r_halt;
    assign fault     = r_fault;
    assign cycle_cnt = r_cycle;
    assign instret   = r_instret;

endmodule

// File: doc/npc_seq_ctrl.md
# npc_seq_ctrl

Multi-cycle sequencer for the NPC core. It replaces the free-running PC-plus-4 register with a fetch/execute state machine. The sequencer issues instruction fetches to memory over a valid/ready request and valid response handshake, and holds the fetched instruction steady for the decoder, ALU and register file. It advances the PC and enables the register write only in the execute cycle. It halts on `ebreak`, flags a fault on fetch timeout, and keeps cycle and retired-instruction counters.

## Interface
Parameters:
- `RESET_PC`, default `32'h80000000`: PC value after reset.
- `TIMEOUT`, default `255`: maximum WAIT cycles before FAULT. Legal range is 1..65535.
- `CNT_W`, default `32`: width of the performance counters.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `imem_req_valid` output 1: fetch request valid.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_addr` output 32: fetch address; always equals `pc`.
- `imem_rsp_valid` input 1: fetch response valid.
- `imem_rsp_data` input 32: fetched instruction.
- `inst` output 32: latched instruction for the decoder.
- `pc` output 32: current PC.
- `dec_reg_wen` input 1: register write request from the decoder.
- `reg_wen` output 1: gated register-file write enable.
- `halt` output 1: `ebreak` reached; sticky.
- `fault` output 1: fetch timeout; sticky.
- `cycle_cnt` output CNT_W: active-cycle counter.
- `instret` output CNT_W: retired-instruction counter.

## Operation
- States:
  - IDLE: only entered from reset.
  - FETCH
  - WAIT
  - EXEC
  - HALT: terminal.
  - FAULT: terminal.
- Values while `rst` is high:
  - state = IDLE
  - `pc` = RESET_PC
  - `inst` = `32'h00000013` (nop)
  - `halt` = 0, `fault` = 0
  - `cycle_cnt` = 0, `instret` = 0
  - timeout counter = 0
  - all outputs driven from state, so `imem_req_valid` = 0 and `reg_wen` = 0.
- IDLE: always goes to FETCH on the next edge.
- FETCH:
  - `imem_req_valid` = 1.
  - If `imem_req_ready` = 1 on a rising edge, go to WAIT and clear the timeout counter.
  - Otherwise stay in FETCH; `pc` and `imem_addr` stay stable.
  - `imem_rsp_valid` is ignored in FETCH.
- WAIT:
  - `imem_req_valid` = 0.
  - If `imem_rsp_valid` = 1, latch `imem_rsp_data` into `inst` and go to EXEC.
  - Otherwise increment the timeout counter. If the counter reaches TIMEOUT, go to FAULT.
  - If the response arrives on the same edge the counter would reach TIMEOUT, the response wins and the state goes to EXEC.
- EXEC:
  - Lasts exactly one cycle.
  - `reg_wen` = `dec_reg_wen`, so the regfile writes on this edge. `reg_wen` is 0 in every other state.
  - Non-`ebreak` instruction:
    - `pc` <= `pc` + 4, modulo 2^32; `32'hFFFFFFFC` wraps to 0.
    - `instret` += 1.
    - Next state is FETCH.
  - `inst` == `32'h00100073` (`ebreak`):
    - `reg_wen` is forced to 0.
    - `pc` is not updated.
    - `instret` += 1.
    - `halt` <= 1; next state is HALT.
- HALT and FAULT:
  - No requests are issued and `reg_wen` = 0.
  - `pc`, `inst` and both counters freeze.
  - Only `rst` exits these states.
- `cycle_cnt` increments on every edge while the state is FETCH, WAIT or EXEC. It wraps modulo 2^CNT_W.
- `instret` also wraps modulo 2^CNT_W.
- The `ebreak` DPI call stays at core level; the core keys it on `halt` rising.
- Reset asserted mid-operation, in any state, returns to the reset values immediately and asynchronously. Any in-flight memory response after reset is ignored, because the state is not WAIT.

## Timing
- Minimum 3 cycles per instruction: FETCH (ready already high), then WAIT (response on the next cycle), then EXEC.
- Memory stalls add cycles one-for-one.
- `inst` changes only on the edge that leaves WAIT. It is stable throughout EXEC and until the next response.
- `pc` changes only on the edge that leaves EXEC; the new value is visible in the following FETCH.
- `halt` and `fault` are registered, asserting on the edge entering HALT or FAULT.
- A response is accepted no earlier than one cycle after the accepting edge of its request.

## Test plan
- **Reset then basic sequence.** Deassert `rst`; memory has ready = 1 and responds one cycle after acceptance with `addi` (`32'h00100093`), `dec_reg_wen` = 1.
  - First request has `imem_addr` = `32'h80000000`.
  - `reg_wen` pulses exactly once, in EXEC.
  - Next `imem_addr` = `32'h80000004`.
  - After 3 instructions: `instret` = 3 and `cycle_cnt` = 9.
- **Request backpressure.** Hold `imem_req_ready` = 0 for 5 cycles.
  - `imem_req_valid` stays 1 with `imem_addr` stable.
  - `cycle_cnt` advances by 5 extra.
  - No write occurs.
- **Ebreak.** Third fetched word is `32'h00100073`.
  - `halt` = 1 and `reg_wen` = 0 in its EXEC.
  - `pc` stays at `32'h80000008`; `instret` = 3.
  - No further requests over 20 cycles; counters frozen.
- **Timeout.** TIMEOUT = 4 and no response arrives.
  - `fault` = 1 after 4 WAIT cycles.
  - Boundary case: a response on the 4th WAIT edge goes to EXEC instead and `fault` stays 0.
- **Reset mid-WAIT.** Assert `rst` mid-cycle while in WAIT.
  - Outputs reach their reset values before the next edge: `pc` = `32'h80000000`, `inst` = `32'h00000013`, counters 0.
  - A late response is ignored.
- **PC wrap.** Set RESET_PC = `32'hFFFFFFFC`.
  - After one instruction, `pc` = `32'h00000000`.
